alu_issue: RTL and testbench

- Issue/writeback stage directly upstream of the RV32 ALU.
- Accepts 32-bit instructions over a valid/ready handshake and decodes OP (0110011) and OP-IMM (0010011) formats.
- Owns the 32x32 register file. Drives fnc3, fnc1, rs1 and rs2 into the ALU from a one-entry execute register, and writes the ALU's rd back into the register file.
- Illegal encodings raise a trap that halts issue until acknowledged.

---
 rtl/alu_issue.sv | 193 +++++++++++++++++++
 tb/tb_alu_issue.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Issue/writeback stage feeding the RV32 ALU: decodes OP/OP-IMM, owns the register file,
// forwards the in-flight result to dependent instructions and traps on illegal encodings.
module alu_issue #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_valid,
    output logic            inst_ready,
    input  logic [31:0]     inst,
    output logic [2:0]      alu_fnc3,
    output logic            alu_fnc1,
    output logic [XLEN-1:0] alu_rs1,
    output logic [XLEN-1:0] alu_rs2,
    input  logic [XLEN-1:0] alu_rd,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [4:0]      res_addr,
    output logic [XLEN-1:0] res_data,
    output logic            trap,
    output logic [31:0]     trap_inst,
    input  logic            trap_ack,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    localparam logic [6:0] OpcOp    = 7'b0110011;
    localparam logic [6:0] OpcOpImm = 7'b0010011;
    localparam logic [6:0] F7Zero   = 7'b0000000;
    localparam logic [6:0] F7Alt    = 7'b0100000;

    typedef enum logic [0:0] {StRun, StTrap} state_e;

    state_e state_q, state_d;

    logic            ex_valid_q, ex_valid_d;
    logic [2:0]      fnc3_q;
    logic            fnc1_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [4:0]      rd_q;
    logic [31:0]     trap_inst_q;
    logic [XLEN-1:0] rf_q [NREG];

    // Instruction fields
    logic [6:0]      opcode;
    logic [4:0]      dec_rd;
    logic [2:0]      dec_fnc3;
    logic [4:0]      rs1_idx;
    logic [4:0]      rs2_idx;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm;

    logic            is_op;
    logic            is_opimm;
    logic            legal;
    logic            dec_fnc1;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] op_b;

    logic            accept;
    logic            issue;
    logic            trap_enter;
    logic            retire;

    assign opcode   = inst[6:0];
    assign dec_rd   = inst[11:7];
    assign dec_fnc3 = inst[14:12];
    assign rs1_idx  = inst[19:15];
    assign rs2_idx  = inst[24:20];
    assign f7       = inst[31:25];
    assign imm      = {{(XLEN-12){inst[31]}}, inst[31:20]};

    assign is_op    = (opcode == OpcOp);
    assign is_opimm = (opcode == OpcOpImm);

    always_comb begin
        legal    = 1'b0;
        dec_fnc1 = 1'b0;
        if (is_op) begin
            legal    = (f7 == F7Zero) ||
                       ((f7 == F7Alt) && ((dec_fnc3 == 3'b000) || (dec_fnc3 == 3'b101)));
            dec_fnc1 = inst[30];
        end else if (is_opimm) begin
            case (dec_fnc3)
                3'b001: legal = (f7 == F7Zero);
                3'b101: begin
                    legal    = (f7 == F7Zero) || (f7 == F7Alt);
                    dec_fnc1 = inst[30];
                end
                default: legal = 1'b1;
            endcase
        end
    end

    // The executing instruction's result is not yet in the register file, so a dependent
    // source takes it straight from the ALU to avoid a bubble.
    always_comb begin
        src1 = '0;
        if (rs1_idx != 5'd0) begin
            if (ex_valid_q && (rs1_idx == rd_q)) begin
                src1 = alu_rd;
            end else begin
                src1 = rf_q[rs1_idx];
            end
        end
    end

    always_comb begin
        src2 = '0;
        if (rs2_idx != 5'd0) begin
            if (ex_valid_q && (rs2_idx == rd_q)) begin
                src2 = alu_rd;
            end else begin
                src2 = rf_q[rs2_idx];
            end
        end
    end

    assign op_b = is_op ? src2 : imm;

    assign inst_ready = (state_q == StRun) && (!ex_valid_q || res_ready);
    assign accept     = inst_valid && inst_ready;
    assign issue      = accept && legal;
    assign trap_enter = accept && !legal;
    assign retire     = ex_valid_q && res_ready;

    always_comb begin
        state_d    = state_q;
        ex_valid_d = ex_valid_q;
        unique case (state_q)
            StRun:   if (trap_enter) state_d = StTrap;
            StTrap:  if (trap_ack) state_d = StRun;
            default: state_d = StRun;
        endcase
        // A same-edge accept keeps the execute register occupied.
        if (issue) begin
            ex_valid_d = 1'b1;
        end else if (retire) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            ex_valid_q  <= 1'b0;
            trap_inst_q <= '0;
            fnc3_q      <= '0;
            fnc1_q      <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
        end else begin
            state_q    <= state_d;
            ex_valid_q <= ex_valid_d;
            if (trap_enter) begin
                trap_inst_q <= inst;
            end
            if (issue) begin
                fnc3_q <= dec_fnc3;
                fnc1_q <= dec_fnc1;
                rs1_q  <= src1;
                rs2_q  <= op_b;
                rd_q   <= dec_rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (retire && (rd_q != 5'd0)) begin
            rf_q[rd_q] <= alu_rd;
        end
    end

    assign alu_fnc3  = fnc3_q;
    assign alu_fnc1  = fnc1_q;
    assign alu_rs1   = rs1_q;
    assign alu_rs2   = rs2_q;
    assign res_valid = ex_valid_q;
    assign res_addr  = rd_q;
    assign res_data  = alu_rd;
    assign trap      = (state_q == StTrap);
    assign trap_inst = trap_inst_q;
    assign dbg_data  = (dbg_addr == 5'd0) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: an architectural model (register array plus one in-flight slot)
// checked against the DUT every cycle, with directed scenarios and randomized traffic.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [2:0]  alu_fnc3;
    logic        alu_fnc1;
    logic [31:0] alu_rs1;
    logic [31:0] alu_rs2;
    logic [31:0] alu_rd;
    logic        res_valid;
    logic        res_ready;
    logic [4:0]  res_addr;
    logic [31:0] res_data;
    logic        trap;
    logic [31:0] trap_inst;
    logic        trap_ack;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Architectural model
    logic [31:0] m_rf [32];
    bit          m_ex;
    bit          m_trap;
    logic [31:0] m_trap_inst;
    logic [2:0]  m_f3;
    logic        m_f1;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [4:0]  m_rd;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(logic [2:0] f3, logic f1, logic [31:0] a,
                                          logic [31:0] b);
        case (f3)
            3'd0:    return f1 ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return {31'd0, $signed(a) < $signed(b)};
            3'd3:    return {31'd0, a < b};
            3'd4:    return a ^ b;
            3'd5:    return f1 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    // Stand-in for the downstream ALU.
    assign alu_rd = alu_f(alu_fnc3, alu_fnc1, alu_rs1, alu_rs2);

    alu_issue #(.XLEN(32), .NREG(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .alu_fnc3   (alu_fnc3),
        .alu_fnc1   (alu_fnc1),
        .alu_rs1    (alu_rs1),
        .alu_rs2    (alu_rs2),
        .alu_rd     (alu_rd),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_addr   (res_addr),
        .res_data   (res_data),
        .trap       (trap),
        .trap_inst  (trap_inst),
        .trap_ack   (trap_ack),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(logic [31:0] w);
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = w[31:25];
        f3 = w[14:12];
        if (w[6:0] == 7'h33) return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        if (w[6:0] == 7'h13) begin
            if (f3 == 3'd1) return f7 == 7'h00;
            if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Value a source register holds once everything already issued has completed.
    function automatic logic [31:0] arch_read(logic [4:0] idx, logic [31:0] inflight);
        if (idx == 5'd0) return 32'd0;
        if (m_ex && idx == m_rd) return inflight;
        return m_rf[idx];
    endfunction

    task automatic model_step();
        bit          rdy;
        logic [31:0] res;
        logic [31:0] a;
        logic [31:0] b;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
            m_ex = 0; m_trap = 0; m_trap_inst = 0;
            m_f3 = 0; m_f1 = 0; m_a = 0; m_b = 0; m_rd = 0;
            return;
        end
        rdy = !m_trap && (!m_ex || res_ready);
        res = alu_f(m_f3, m_f1, m_a, m_b);
        a   = arch_read(inst[19:15], res);
        b   = arch_read(inst[24:20], res);
        if (m_ex && res_ready) begin
            if (m_rd != 5'd0) m_rf[m_rd] = res;
            m_ex = 0;
        end
        if (m_trap && trap_ack) m_trap = 0;
        if (inst_valid && rdy) begin
            if (is_legal(inst)) begin
                m_ex = 1;
                m_f3 = inst[14:12];
                m_rd = inst[11:7];
                m_a  = a;
                if (inst[6:0] == 7'h33) begin
                    m_b  = b;
                    m_f1 = inst[30];
                end else begin
                    m_b  = {{20{inst[31]}}, inst[31:20]};
                    m_f1 = (inst[14:12] == 3'd5) ? inst[30] : 1'b0;
                end
            end else begin
                m_trap      = 1;
                m_trap_inst = inst;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic issue1(logic [31:0] w);
        inst_valid = 1'b1;
        inst       = w;
        cycle();
        inst_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("inst_ready", inst_ready, !m_trap && (!m_ex || res_ready));
            check("res_valid", res_valid, m_ex);
            check("trap", trap, m_trap);
            check("trap_inst", trap_inst, m_trap_inst);
            check("dbg_data", dbg_data, (dbg_addr == 5'd0) ? 32'd0 : m_rf[dbg_addr]);
            if (m_ex) begin
                check("alu_fnc3", alu_fnc3, m_f3);
                check("alu_fnc1", alu_fnc1, m_f1);
                check("alu_rs1", alu_rs1, m_a);
                check("alu_rs2", alu_rs2, m_b);
                check("res_addr", res_addr, m_rd);
                check("res_data", res_data, alu_f(m_f3, m_f1, m_a, m_b));
            end
        end
    end

    function automatic logic [31:0] gen_inst();
        logic [4:0]  rd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] im;
        int          k;
        rd = 5'($urandom % 8);
        r1 = 5'($urandom % 8);
        r2 = 5'($urandom % 8);
        f3 = 3'($urandom);
        k  = int'($urandom % 10);
        if (k < 5) begin
            f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom % 2 == 0) ? 7'h20 : 7'h00;
            if ($urandom % 12 == 0) f7 = 7'($urandom);
            return {f7, r2, r1, f3, rd, 7'h33};
        end else if (k < 9) begin
            im = 12'($urandom);
            if (f3 == 3'd1) im[11:5] = 7'h00;
            if (f3 == 3'd5) im[11:5] = ($urandom % 2 == 0) ? 7'h20 : 7'h00;
            if ($urandom % 12 == 0) im[11:5] = 7'($urandom);
            return {im, r1, f3, rd, 7'h13};
        end
        return $urandom;
    endfunction

    initial begin
        rst = 1'b1; inst_valid = 1'b0; inst = 32'd0; res_ready = 1'b0;
        trap_ack = 1'b0; dbg_addr = 5'd0;
        cycle();
        cycle();
        rst = 1'b0;
        chk_en = 1'b1;
        res_ready = 1'b1;

        // Reset values
        @(negedge clk);
        check("rst_res_valid", res_valid, 32'd0);
        check("rst_alu_rs1", alu_rs1, 32'd0);
        check("rst_alu_rs2", alu_rs2, 32'd0);
        check("rst_res_addr", res_addr, 32'd0);
        check("rst_trap_inst", trap_inst, 32'd0);
        check("rst_inst_ready", inst_ready, 32'd1);

        // ADDI x1,x0,-1
        issue1(32'hFFF00093);
        dbg_addr = 5'd1;
        @(negedge clk);
        check("addi_rs1", alu_rs1, 32'd0);
        check("addi_rs2", alu_rs2, 32'hFFFFFFFF);
        check("addi_fnc3", alu_fnc3, 32'd0);
        check("addi_fnc1", alu_fnc1, 32'd0);
        check("addi_rd", res_addr, 32'd1);
        cycle();
        @(negedge clk);
        check("x1_wb", dbg_data, 32'hFFFFFFFF);

        // ADDI x2,x0,5 then SUB x3,x2,x2 back-to-back
        issue1(32'h00500113);
        issue1(32'h402101B3);
        dbg_addr = 5'd2;
        @(negedge clk);
        check("sub_fwd_rs1", alu_rs1, 32'd5);
        check("sub_fwd_rs2", alu_rs2, 32'd5);
        check("sub_fnc1", alu_fnc1, 32'd1);
        check("x2_wb", dbg_data, 32'd5);
        cycle();
        dbg_addr = 5'd3;
        @(negedge clk);
        check("x3_zero", dbg_data, 32'd0);

        // ADDI x4,x0,7 under backpressure
        res_ready = 1'b0;
        dbg_addr  = 5'd4;
        issue1(32'h00700213);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready", inst_ready, 32'd0);
            check("bp_rs2", alu_rs2, 32'd7);
            check("bp_x4_old", dbg_data, 32'd0);
            cycle();
        end
        res_ready = 1'b1;
        cycle();
        @(negedge clk);
        check("x4_wb", dbg_data, 32'd7);

        // Bad opcode
        issue1(32'h0000007F);
        @(negedge clk);
        check("trap_set", trap, 32'd1);
        check("trap_word", trap_inst, 32'h0000007F);
        check("trap_ready", inst_ready, 32'd0);
        trap_ack = 1'b1;
        cycle();
        trap_ack = 1'b0;
        @(negedge clk);
        check("trap_clr", trap, 32'd0);
        check("trap_clr_ready", inst_ready, 32'd1);

        // x1 = 0x80000000 via ADDI/SLLI, then SRAI x5,x1,4
        issue1(32'h00100093);
        issue1(32'h01F09093);
        issue1(32'h4040D293);
        @(negedge clk);
        check("srai_fnc3", alu_fnc3, 32'd5);
        check("srai_fnc1", alu_fnc1, 32'd1);
        check("srai_rs1", alu_rs1, 32'h80000000);
        check("srai_rs2", alu_rs2, 32'h00000404);
        check("srai_res", res_data, 32'hF8000000);
        issue1(32'h8040D293);
        @(negedge clk);
        check("srai_bad_trap", trap, 32'd1);
        trap_ack = 1'b1;
        cycle();
        trap_ack = 1'b0;

        // Write to x0 discarded; reset drops an executing instruction
        issue1(32'h00900013);
        cycle();
        dbg_addr = 5'd0;
        @(negedge clk);
        check("x0_zero", dbg_data, 32'd0);
        res_ready = 1'b0;
        issue1(32'h00300313);
        @(negedge clk);
        check("x6_exec", res_valid, 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        res_ready = 1'b1;
        dbg_addr = 5'd6;
        @(negedge clk);
        check("x6_discard", dbg_data, 32'd0);
        check("rst_drop_valid", res_valid, 32'd0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst        = ($urandom % 300 == 0);
            inst_valid = ($urandom % 4 != 0);
            inst       = gen_inst();
            res_ready  = ($urandom % 4 != 0);
            trap_ack   = ($urandom % 3 == 0);
            dbg_addr   = 5'($urandom % 9);
            cycle();
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
